// File: rtl/xfer_pkg.sv
// Shared constants and types for the capture-to-serial framer.
package xfer_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int unsigned MAX_CH_NO = 16;
  localparam int unsigned HDR_CH_W  = 4;
  localparam int unsigned HDR_SEQ_W = 4;

  localparam logic [2:0] ST_ARB  = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;

  typedef enum logic [2:0] {
    S_ARB  = ST_ARB,
    S_SYNC = ST_SYNC,
    S_HDR  = ST_HDR,
    S_PAY  = ST_PAY,
    S_CSUM = ST_CSUM
  } state_t;

  typedef struct packed {
    logic [HDR_CH_W-1:0]  ch;
    logic [HDR_SEQ_W-1:0] seq;
  } hdr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester strictly after ptr, wrapping.
module rr_arbiter
  import xfer_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [HDR_CH_W-1:0]   ptr,
  output logic [HDR_CH_W-1:0]   grant,
  output logic                  any_req
);

  always_comb begin
    logic          found;
    int unsigned   idx;
    logic [N-1:0]  sh;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    sh    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      sh = req >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        grant = HDR_CH_W'(idx);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/xfer_framer.sv
// Round-robin word capture, serialised as SYNC / HDR / payload MSB-first / XOR checksum.
module xfer_framer
  import xfer_pkg::*;
#(
  parameter int unsigned CH_NO  = 4,
  parameter int unsigned DATA_W = 32,
  parameter logic [7:0]  SYNC   = SYNC_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_W*CH_NO-1:0]   i_data,
  input  logic [CH_NO-1:0]          i_available,
  input  logic [CH_NO-1:0]          i_ch_enable,
  output logic [CH_NO-1:0]          o_read,
  output logic [7:0]                o_byte,
  output logic                      o_byte_valid,
  input  logic                      i_byte_ready,
  output logic                      o_busy,
  output logic [15:0]               o_frame_count
);

  localparam int unsigned PAY_N = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(PAY_N) + 1;

  state_t                state_q, state_nxt;
  logic [DATA_W-1:0]     word_q, word_nxt;
  logic [7:0]            csum_q, csum_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [HDR_SEQ_W-1:0]  seq_q, seq_nxt;
  logic [HDR_CH_W-1:0]   ptr_q, ptr_nxt;
  logic [CH_NO-1:0]      read_nxt;
  logic [7:0]            byte_nxt;
  logic                  valid_nxt, busy_nxt;
  logic [15:0]           fcnt_nxt;

  logic [CH_NO-1:0]      req;
  logic [HDR_CH_W-1:0]   grant;
  logic                  any_req;
  logic [DATA_W-1:0]     word_sel;
  logic                  xfer;
  hdr_t                  hdr;

  assign req  = i_available & i_ch_enable;
  assign xfer = o_byte_valid & i_byte_ready;

  rr_arbiter #(.N(CH_NO)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .grant   (grant),
    .any_req (any_req)
  );

  always_comb begin
    word_sel = '0;
    for (int unsigned k = 0; k < CH_NO; k++) begin
      if (grant == HDR_CH_W'(k)) word_sel = i_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    hdr.ch  = ptr_q;
    hdr.seq = seq_q;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt = state_q;
    word_nxt  = word_q;
    csum_nxt  = csum_q;
    cnt_nxt   = cnt_q;
    seq_nxt   = seq_q;
    ptr_nxt   = ptr_q;
    read_nxt  = '0;
    byte_nxt  = o_byte;
    valid_nxt = o_byte_valid;
    fcnt_nxt  = o_frame_count;
    case (state_q)
      S_ARB: begin
        if (any_req) begin
          word_nxt  = word_sel;
          read_nxt  = CH_NO'(1) << grant;
          ptr_nxt   = grant;
          byte_nxt  = SYNC;
          valid_nxt = 1'b1;
          csum_nxt  = '0;
          state_nxt = S_SYNC;
        end
      end
      S_SYNC: begin
        if (xfer) begin
          byte_nxt  = hdr;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (xfer) begin
          csum_nxt  = csum_q ^ o_byte;
          byte_nxt  = word_q[DATA_W-1 -: 8];
          word_nxt  = word_q << 8;
          cnt_nxt   = '0;
          state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        if (xfer) begin
          csum_nxt = csum_q ^ o_byte;
          if (cnt_q == CNT_W'(PAY_N - 1)) begin
            byte_nxt  = csum_q ^ o_byte;
            state_nxt = S_CSUM;
          end else begin
            byte_nxt = word_q[DATA_W-1 -: 8];
            word_nxt = word_q << 8;
            cnt_nxt  = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          valid_nxt = 1'b0;
          byte_nxt  = '0;
          seq_nxt   = seq_q + HDR_SEQ_W'(1);
          fcnt_nxt  = o_frame_count + 16'd1;
          state_nxt = S_ARB;
        end
      end
      default: state_nxt = S_ARB;
    endcase
    busy_nxt = (state_nxt != S_ARB);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_ARB;
      word_q        <= '0;
      csum_q        <= '0;
      cnt_q         <= '0;
      seq_q         <= '0;
      ptr_q         <= HDR_CH_W'(CH_NO - 1);
      o_read        <= '0;
      o_byte        <= '0;
      o_byte_valid  <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_count <= '0;
    end else begin
      state_q       <= state_nxt;
      word_q        <= word_nxt;
      csum_q        <= csum_nxt;
      cnt_q         <= cnt_nxt;
      seq_q         <= seq_nxt;
      ptr_q         <= ptr_nxt;
      o_read        <= read_nxt;
      o_byte        <= byte_nxt;
      o_byte_valid  <= valid_nxt;
      o_busy        <= busy_nxt;
      o_frame_count <= fcnt_nxt;
    end
  end

endmodule

// File: tb/tb_xfer_framer.sv
// Randomised bench for xfer_framer against a frame-level queue model, plus directed literal pins.
module tb_xfer_framer;

  localparam int unsigned CH  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned CH2 = 8;
  localparam int unsigned DW2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [DW*CH-1:0]    data;
  logic [CH-1:0]       avail, en, rd;
  logic [7:0]          byte_o;
  logic                valid, ready, busy;
  logic [15:0]         fcnt;

  logic [DW2*CH2-1:0]  data2;
  logic [CH2-1:0]      avail2, en2, rd2;
  logic [7:0]          byte2;
  logic                valid2, ready2, busy2;
  logic [15:0]         fcnt2;

  xfer_framer #(.CH_NO(CH), .DATA_W(DW), .SYNC(8'hA5)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_available(avail),
    .i_ch_enable(en), .o_read(rd), .o_byte(byte_o), .o_byte_valid(valid),
    .i_byte_ready(ready), .o_busy(busy), .o_frame_count(fcnt)
  );

  xfer_framer #(.CH_NO(CH2), .DATA_W(DW2), .SYNC(8'hA5)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data2), .i_available(avail2),
    .i_ch_enable(en2), .o_read(rd2), .o_byte(byte2), .o_byte_valid(valid2),
    .i_byte_ready(ready2), .o_busy(busy2), .o_frame_count(fcnt2)
  );

  int nvec = 0;
  int nerr = 0;

  // Behavioural model state: the bytes still owed for the current frame.
  logic [7:0]    mq[$];
  logic [7:0]    mlog[$], dlog[$], hlog[$];
  int            glog[$];
  int            m_ptr, m_seq, m_cnt;
  logic [CH-1:0] m_read;
  logic [7:0]    d_byte_s;
  logic          d_valid_s;
  logic [DW-1:0] words[CH];
  int            src[CH];
  int            rdc[CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] req;
    logic [DW-1:0] w;
    logic [7:0]    hdr, cs, pb;
    int            g;
    if (d_valid_s && ready && !rst) dlog.push_back(d_byte_s);
    if (rst) begin
      mq.delete();
      m_seq  = 0;
      m_cnt  = 0;
      m_ptr  = CH - 1;
      m_read = '0;
      return;
    end
    m_read = '0;
    if (mq.size() == 0) begin
      req = avail & en;
      if (req != '0) begin
        g = -1;
        for (int i = 1; i <= int'(CH); i++) begin
          int c;
          c = (m_ptr + i) % CH;
          if (g < 0 && req[c]) g = c;
        end
        m_ptr  = g;
        m_read = CH'(1) << g;
        glog.push_back(g);
        w   = data[g*DW +: DW];
        hdr = 8'((g << 4) | m_seq);
        hlog.push_back(hdr);
        cs  = hdr;
        mq.push_back(8'hA5);
        mq.push_back(hdr);
        for (int b = DW/8 - 1; b >= 0; b--) begin
          pb = w[b*8 +: 8];
          mq.push_back(pb);
          cs = cs ^ pb;
        end
        mq.push_back(cs);
      end
    end else if (ready) begin
      mlog.push_back(mq.pop_front());
      if (mq.size() == 0) begin
        m_seq = (m_seq + 1) % 16;
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
  endtask

  task automatic check_outputs();
    logic       ev;
    logic [7:0] eb;
    d_byte_s  = byte_o;
    d_valid_s = valid;
    ev = (mq.size() > 0);
    eb = ev ? mq[0] : 8'h00;
    check("byte_valid", 64'(valid), 64'(ev));
    check("byte", 64'(byte_o), 64'(eb));
    check("read", 64'(rd), 64'(m_read));
    check("busy", 64'(busy), 64'(ev));
    check("frame_count", 64'(fcnt), 64'(m_cnt));
    for (int k = 0; k < int'(CH); k++) begin
      if (rd[k]) begin
        rdc[k]++;
        src[k]--;
        words[k] = $urandom;
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < int'(CH); k++) begin
      data[k*DW +: DW] = words[k];
      avail[k] = (src[k] > 0);
    end
  endtask

  task automatic cycle();
    drive();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_logs();
    mlog.delete(); dlog.delete(); hlog.delete(); glog.delete();
    for (int k = 0; k < int'(CH); k++) rdc[k] = 0;
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic refill(input int odds);
    for (int k = 0; k < int'(CH); k++)
      if ($urandom_range(0, odds) == 0) src[k]++;
  endtask

  initial begin
    logic [7:0] exp1[7];
    logic [7:0] exp5[7];
    logic [7:0] exp7[5];
    logic [7:0] hdr2[5];
    int         ord2[5];
    int         ord4[4];
    logic [7:0] b2[$];
    int         waited;

    exp1 = '{8'hA5, 8'h20, 8'h12, 8'h34, 8'h56, 8'h78, 8'h28};
    exp5 = '{8'hA5, 8'h10, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hD9};
    exp7 = '{8'hA5, 8'h70, 8'hBE, 8'hEF, 8'h21};
    hdr2 = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h04};
    ord2 = '{0, 1, 2, 3, 0};
    ord4 = '{0, 1, 3, 0};

    rst = 1'b1; ready = 1'b1; en = '1; d_valid_s = 1'b0; d_byte_s = '0;
    m_ptr = CH - 1; m_seq = 0; m_cnt = 0; m_read = '0;
    data2 = '0; avail2 = '0; en2 = '1; ready2 = 1'b1;
    for (int k = 0; k < int'(CH); k++) begin
      src[k] = 0; words[k] = $urandom; rdc[k] = 0;
    end

    // Reset state
    repeat (3) cycle();
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_fcnt", 64'(fcnt), 64'(0));
    check("rst_read", 64'(rd), 64'(0));
    rst = 1'b0;

    // Single word on channel 2
    clear_logs();
    src[2] = 1; words[2] = 32'h12345678;
    repeat (12) cycle();
    check("p1_len", 64'(dlog.size()), 64'(7));
    for (int i = 0; i < 7; i++) begin
      check("p1_dut_byte", 64'(dlog[i]), 64'(exp1[i]));
      check("p1_model_byte", 64'(mlog[i]), 64'(exp1[i]));
    end
    check("p1_fcnt", 64'(fcnt), 64'(1));
    check("p1_read2_pulses", 64'(rdc[2]), 64'(1));

    // Round robin, all channels continuously available
    reset_cycle();
    clear_logs();
    for (int k = 0; k < int'(CH); k++) src[k] = 1000;
    repeat (42) cycle();
    for (int f = 0; f < 5; f++) begin
      check("p2_grant", 64'(glog[f]), 64'(ord2[f]));
      check("p2_model_hdr", 64'(hlog[f]), 64'(hdr2[f]));
      check("p2_dut_hdr", 64'(dlog[7*f+1]), 64'(hdr2[f]));
    end

    // Random backpressure with random arrivals
    for (int c = 0; c < 400; c++) begin
      ready = ($urandom_range(0, 2) != 0);
      refill(5);
      cycle();
    end
    ready = 1'b1;

    // Channel mask 1011
    reset_cycle();
    clear_logs();
    en = 4'b1011;
    for (int k = 0; k < int'(CH); k++) src[k] = 1000;
    repeat (34) cycle();
    for (int f = 0; f < 4; f++) check("p4_grant", 64'(glog[f]), 64'(ord4[f]));
    check("p4_ch2_reads", 64'(rdc[2]), 64'(0));
    en = '1;

    // Reset in mid-payload
    for (int k = 0; k < int'(CH); k++) src[k] = 0;
    reset_cycle();
    clear_logs();
    src[1] = 1; words[1] = $urandom;
    waited = 0;
    while (dlog.size() < 3 && waited < 20) begin
      cycle();
      waited++;
    end
    check("p5_three_bytes", 64'(dlog.size()), 64'(3));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("p5_valid", 64'(valid), 64'(0));
    check("p5_read", 64'(rd), 64'(0));
    check("p5_fcnt", 64'(fcnt), 64'(0));
    clear_logs();
    src[1] = 1; words[1] = 32'hCAFEF00D;
    repeat (12) cycle();
    check("p5_len", 64'(dlog.size()), 64'(7));
    for (int i = 0; i < 7; i++) check("p5_byte", 64'(dlog[i]), 64'(exp5[i]));

    // Fully random traffic, enables and occasional resets
    for (int c = 0; c < 1500; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) en = CH'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      refill(4);
      cycle();
    end
    rst = 1'b0; ready = 1'b1; en = '1;

    // Eight 16-bit channels, channel 7
    for (int k = 0; k < int'(CH); k++) src[k] = 0;
    reset_cycle();
    data2[7*DW2 +: DW2] = 16'hBEEF;
    avail2 = 8'h80;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (rd2 != '0) begin
        check("p7_read", 64'(rd2), 64'(8'h80));
        avail2 = '0;
      end
      if (valid2) b2.push_back(byte2);
    end
    check("p7_len", 64'(b2.size()), 64'(5));
    for (int i = 0; i < 5; i++) check("p7_byte", 64'(b2[i]), 64'(exp7[i]));
    check("p7_fcnt", 64'(fcnt2), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
